// File: rtl/cmp_unit_arbiter.sv
// Round-robin arbiter sharing the ALU compare path between branch (req0) and set-instr (req1) requesters.
// Latency: accept T, alu_start T+1, resp_valid one cycle after alu_done (or after TIMEOUT WAIT cycles).
// Backpressure: readies only in IDLE; response held stable until resp_ready, no accept during RESP.
module cmp_unit_arbiter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_start,
    input  logic             alu_done,
    input  logic             alu_zero,
    input  logic             alu_neg,
    input  logic             alu_ofl,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic             resp_cmp,
    output logic             resp_err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic       last_grant;
    logic       armed;
    logic       id_q;
    logic [1:0] op_q;
    logic [7:0] wait_cnt;
    logic       grant;
    logic       idle_open;
    logic       take;
    logic       cmp_eval;

    // Tie goes to the requester that did not win last; a lone requester always wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid)
            grant = ~last_grant;
        else if (req1_valid)
            grant = 1'b1;
    end

    // armed keeps readies low from reset assertion until the first edge after release.
    assign idle_open  = armed && (state == S_IDLE);
    assign req0_ready = idle_open && req0_valid && !grant;
    assign req1_ready = idle_open && req1_valid && grant;
    assign take       = req0_ready || req1_ready;

    always_comb begin
        cmp_eval = 1'b0;
        case (op_q)
            2'b00:   cmp_eval = alu_zero;
            2'b01:   cmp_eval = alu_neg;
            2'b10:   cmp_eval = alu_neg | alu_zero;
            default: cmp_eval = alu_ofl;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            armed      <= 1'b0;
            id_q       <= 1'b0;
            op_q       <= 2'b00;
            wait_cnt   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_start  <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_cmp   <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            armed     <= 1'b1;
            alu_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (take) begin
                        op_q       <= grant ? req1_op : req0_op;
                        alu_a      <= grant ? req1_a : req0_a;
                        alu_b      <= grant ? req1_b : req0_b;
                        id_q       <= grant;
                        last_grant <= grant;
                        alu_start  <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (alu_done) begin
                        resp_cmp   <= cmp_eval;
                        resp_err   <= 1'b0;
                        resp_id    <= id_q;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        resp_cmp   <= 1'b0;
                        resp_err   <= 1'b1;
                        resp_id    <= id_q;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_unit_arbiter.sv
// Directed bench for cmp_unit_arbiter: vector table of single compares plus multi-cycle corner sequences.
module tb_cmp_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [15:0] alu_a, alu_b;
    logic        alu_start, alu_done, alu_zero, alu_neg, alu_ofl;
    logic        resp_valid, resp_ready, resp_id, resp_cmp, resp_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cmp_unit_arbiter #(.WIDTH(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start), .alu_done(alu_done),
        .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_ofl(alu_ofl),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_cmp(resp_cmp), .resp_err(resp_err)
    );

    typedef struct {
        bit          who;
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        bit          z;
        bit          n;
        bit          o;
        bit          exp_cmp;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Single uncontested compare, entered while the DUT is idle.
    task automatic do_txn(input vec_t v, input string tag);
        if (v.who) begin
            req1_valid = 1'b1; req1_op = v.op; req1_a = v.a; req1_b = v.b;
        end else begin
            req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b;
        end
        #1;
        chk({tag, "_rdy0"}, 32'(req0_ready), 32'(!v.who));
        chk({tag, "_rdy1"}, 32'(req1_ready), 32'(v.who));
        next_cycle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk({tag, "_start"}, 32'(alu_start), 32'd1);
        chk({tag, "_alu_a"}, 32'(alu_a), 32'(v.a));
        chk({tag, "_alu_b"}, 32'(alu_b), 32'(v.b));
        next_cycle();
        alu_done = 1'b1; alu_zero = v.z; alu_neg = v.n; alu_ofl = v.o;
        #1;
        chk({tag, "_start_off"}, 32'(alu_start), 32'd0);
        next_cycle();
        alu_done = 1'b0; alu_zero = 1'b0; alu_neg = 1'b0; alu_ofl = 1'b0;
        resp_ready = 1'b1;
        #1;
        chk({tag, "_rvld"}, 32'(resp_valid), 32'd1);
        chk({tag, "_rid"}, 32'(resp_id), 32'(v.who));
        chk({tag, "_rcmp"}, 32'(resp_cmp), 32'(v.exp_cmp));
        chk({tag, "_rerr"}, 32'(resp_err), 32'd0);
        next_cycle();
        resp_ready = 1'b0;
        #1;
        chk({tag, "_rvld_drop"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int waited;
        int seen;
        bit g;

        vecs[0] = '{1'b0, 2'b00, 16'h0005, 16'h0005, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 2'b01, 16'h0002, 16'h0007, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 2'b10, 16'h0009, 16'h0009, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 2'b11, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 2'b00, 16'h0005, 16'h0006, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 2'b01, 16'h0010, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 2'b10, 16'h0100, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 2'b11, 16'h1234, 16'h4321, 1'b1, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 16'h1111; req0_b = 16'h2222;
        req1_valid = 1'b1; req1_op = 2'b00; req1_a = 16'h3333; req1_b = 16'h4444;
        alu_done = 1'b0; alu_zero = 1'b0; alu_neg = 1'b0; alu_ofl = 1'b0;
        resp_ready = 1'b0;

        // Reset state with both requesters asserting valid.
        #12;
        chk("rst_rdy0", 32'(req0_ready), 32'd0);
        chk("rst_rdy1", 32'(req1_ready), 32'd0);
        chk("rst_start", 32'(alu_start), 32'd0);
        chk("rst_rvld", 32'(resp_valid), 32'd0);
        chk("rst_rid", 32'(resp_id), 32'd0);
        chk("rst_rcmp", 32'(resp_cmp), 32'd0);
        chk("rst_rerr", 32'(resp_err), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        #5;
        rst_n = 1'b1;
        #1;
        chk("rel_rdy0", 32'(req0_ready), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        next_cycle();

        for (int i = 0; i < 8; i++)
            do_txn(vecs[i], $sformatf("v%0d", i));

        // Fresh reset, then both requesters held valid: expect 0,1,0,1.
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 16'h0001; req0_b = 16'h0001;
        req1_valid = 1'b1; req1_op = 2'b01; req1_a = 16'h0020; req1_b = 16'h0030;
        for (int k = 0; k < 4; k++) begin
            g = k[0];
            #1;
            chk($sformatf("rr%0d_rdy0", k), 32'(req0_ready), 32'(!g));
            chk($sformatf("rr%0d_rdy1", k), 32'(req1_ready), 32'(g));
            next_cycle();
            #1;
            chk($sformatf("rr%0d_issue_rdy", k), 32'(req0_ready | req1_ready), 32'd0);
            chk($sformatf("rr%0d_alu_a", k), 32'(alu_a), g ? 32'h20 : 32'h1);
            next_cycle();
            alu_done = 1'b1; alu_zero = 1'b1; alu_neg = 1'b0;
            #1;
            chk($sformatf("rr%0d_wait_rdy", k), 32'(req0_ready | req1_ready), 32'd0);
            next_cycle();
            alu_done = 1'b0; alu_zero = 1'b0;
            resp_ready = 1'b1;
            #1;
            chk($sformatf("rr%0d_rid", k), 32'(resp_id), 32'(g));
            chk($sformatf("rr%0d_rcmp", k), 32'(resp_cmp), 32'(!g));
            chk($sformatf("rr%0d_resp_rdy", k), 32'(req0_ready | req1_ready), 32'd0);
            next_cycle();
            resp_ready = 1'b0;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Timeout: alu_done never arrives.
        next_cycle();
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 16'h0003; req0_b = 16'h0004;
        #1;
        chk("to_rdy0", 32'(req0_ready), 32'd1);
        next_cycle();
        req0_valid = 1'b0;
        #1;
        chk("to_start", 32'(alu_start), 32'd1);
        waited = 0;
        for (int c = 0; c < 30; c++) begin
            next_cycle();
            #1;
            if (resp_valid) break;
            waited++;
        end
        chk("to_wait_cycles", 32'(waited), 32'd8);
        chk("to_rvld", 32'(resp_valid), 32'd1);
        chk("to_rerr", 32'(resp_err), 32'd1);
        chk("to_rcmp", 32'(resp_cmp), 32'd0);
        chk("to_rid", 32'(resp_id), 32'd0);
        alu_done = 1'b1; alu_zero = 1'b1;
        next_cycle();
        #1;
        chk("to_late_rvld", 32'(resp_valid), 32'd1);
        chk("to_late_rerr", 32'(resp_err), 32'd1);
        chk("to_late_rcmp", 32'(resp_cmp), 32'd0);
        resp_ready = 1'b1;
        next_cycle();
        resp_ready = 1'b0;
        #1;
        chk("to_idle_rvld", 32'(resp_valid), 32'd0);
        next_cycle();
        alu_done = 1'b0; alu_zero = 1'b0;
        #1;
        chk("to_idle_start", 32'(alu_start), 32'd0);
        chk("to_idle_rvld2", 32'(resp_valid), 32'd0);

        // Backpressure: resp_ready low for 5 cycles while both requesters wait.
        next_cycle();
        req1_valid = 1'b1; req1_op = 2'b10; req1_a = 16'h0008; req1_b = 16'h0009;
        #1;
        chk("bp_rdy1", 32'(req1_ready), 32'd1);
        next_cycle();
        req1_valid = 1'b0;
        next_cycle();
        alu_done = 1'b1; alu_neg = 1'b1; alu_zero = 1'b0;
        next_cycle();
        alu_done = 1'b0; alu_neg = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp%0d_rvld", c), 32'(resp_valid), 32'd1);
            chk($sformatf("bp%0d_rid", c), 32'(resp_id), 32'd1);
            chk($sformatf("bp%0d_rcmp", c), 32'(resp_cmp), 32'd1);
            chk($sformatf("bp%0d_rdy", c), 32'(req0_ready | req1_ready), 32'd0);
            next_cycle();
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_hs_rvld", 32'(resp_valid), 32'd1);
        chk("bp_hs_rdy", 32'(req0_ready | req1_ready), 32'd0);
        next_cycle();
        resp_ready = 1'b0;
        #1;
        chk("bp_done_rvld", 32'(resp_valid), 32'd0);
        chk("bp_next_rdy0", 32'(req0_ready), 32'd1);
        chk("bp_next_rdy1", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Reset during WAIT after a req0 win: transaction dropped, tie then goes to req0.
        next_cycle();
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 16'hABCD; req0_b = 16'h1234;
        #1;
        chk("rw_rdy0", 32'(req0_ready), 32'd1);
        next_cycle();
        req0_valid = 1'b0;
        next_cycle();
        #1;
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rw_alu_a", 32'(alu_a), 32'd0);
        chk("rw_alu_b", 32'(alu_b), 32'd0);
        chk("rw_rvld", 32'(resp_valid), 32'd0);
        chk("rw_rdy", 32'(req0_ready | req1_ready), 32'd0);
        next_cycle();
        alu_done = 1'b1;
        next_cycle();
        rst_n = 1'b1;
        #1;
        chk("rw_rel_rdy", 32'(req0_ready | req1_ready), 32'd0);
        next_cycle();
        #1;
        chk("rw_tie_rdy0", 32'(req0_ready), 32'd1);
        chk("rw_tie_rdy1", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            #1;
            if (resp_valid) seen++;
        end
        alu_done = 1'b0;
        chk("rw_no_resp", 32'(seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cmp_unit_arbiter.md
Name: cmp_unit_arbiter

Overview:
- Shares the single ALU compare path (ALU subtract plus flag evaluation) between two requesters: req0 = branch resolution, req1 = SLT/SLE/SEQ/SCO set-instructions.
- Round-robin arbitration, operand latching and ALU start/done sequencing.
- Evaluates the captured Zero/Neg/Ofl flags per CmpOp and returns one tagged response with a valid/ready handshake.
- Sits between decode/execute control and the shared ALU.

Parameters:
- WIDTH, 16, operand width.
- TIMEOUT, 8, maximum cycles spent in WAIT for alu_done before an error response (legal range 2..255).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has a compare pending.
- req0_ready  output  1  req0 accepted this cycle (transfer = valid & ready).
- req0_op  input  2  CmpOp: 00 ==, 01 <, 10 <=, 11 carry-out.
- req0_a, req0_b  input  WIDTH  operands.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0.
- alu_a, alu_b  output  WIDTH  operands to the shared ALU (ALU computes a - b).
- alu_start  output  1  one-cycle start pulse.
- alu_done  input  1  ALU result/flags valid this cycle.
- alu_zero, alu_neg, alu_ofl  input  1  ALU flags, sampled only when alu_done=1 in WAIT.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer accepts response.
- resp_id  output  1  requester that owns the response.
- resp_cmp  output  1  compare result.
- resp_err  output  1  ALU timeout occurred.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; alu_a, alu_b = 0; last_grant=1 so req0 wins the first tie; wait counter = 0. An in-flight transaction is dropped with no response. Outputs stay 0 until the first clk edge after rst_n rises.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If exactly one reqN_valid=1, drive that reqN_ready=1 combinationally.
  - If both are valid, grant the one not equal to last_grant.
  - On the transfer edge: latch op, a, b and id; update last_grant=id; go to ISSUE.
  - The ready of the non-granted requester is 0. Both readies are 0 outside IDLE.
- ISSUE: alu_start=1 for exactly this one cycle; clear wait counter; go to WAIT. alu_done is ignored in ISSUE.
- WAIT:
  - If alu_done=1: capture cmp and go to RESP with err=0. The capture rule is op 00 -> zero; 01 -> neg; 10 -> neg|zero; 11 -> ofl.
  - Else if counter==TIMEOUT-1: go to RESP with resp_cmp=0, resp_err=1.
  - Else increment the counter.
  - WAIT lasts at most TIMEOUT cycles.
- alu_a and alu_b hold the latched operands from ISSUE through RESP. They keep their last value in IDLE.
- RESP:
  - resp_valid=1; resp_id, resp_cmp and resp_err stay stable while resp_valid=1 and resp_ready=0.
  - On resp_valid & resp_ready, go to IDLE; resp_valid drops the next cycle.
  - No new request is accepted in the RESP handshake cycle: the earliest re-accept is the cycle after returning to IDLE.
- Latency: accept at cycle T, alu_start at T+1. If alu_done arrives at T+2, resp_valid=1 at T+3. Throughput is at most one compare per 4 cycles.
- A requester deasserting valid without a transfer simply loses its turn. last_grant changes only on a transfer.
- A request held while the other is being served is granted next, which gives starvation freedom.
- Any alu_done outside WAIT is ignored, with no state change.
- Response outputs are registered; readies depend combinationally only on state, valids and last_grant.

Test Plan:
- Reset then single req0 (op=00, a=16'h0005, b=16'h0005): req0_ready=1 at T, alu_start at T+1. ALU returns zero=1 at T+2, giving resp_valid at T+3 with id=0, cmp=1, err=0.
- Simultaneous req0 and req1 held valid after reset: grants go 0,1,0,1 over four back-to-back transactions; each readyN pulses exactly once per grant.
- Flag mapping: op=01 with neg=1, zero=0 -> cmp=1; op=10 with neg=0, zero=1 -> cmp=1; op=11 with ofl=1 -> cmp=1; op=00 with zero=0 -> cmp=0.
- alu_done never asserted with TIMEOUT=8: exactly 8 WAIT cycles, then resp_valid=1, err=1, cmp=0. A late alu_done afterwards is ignored.
- resp_ready held 0 for 5 cycles: resp_valid, id and cmp stay stable; no reqN_ready asserts; completion follows the first resp_ready=1 cycle.
- rst_n pulsed low during WAIT: all outputs go 0 immediately; no response is ever emitted; the next request after rst_n rises is granted to req0 on a tie.
